// File: rtl/ssp_rx_fifo_param.sv
// SSP receive FIFO: parametrised circular buffer with first-word fall-through
// head, level/full/empty status, watermark and sticky overrun interrupts.
module ssp_rx_fifo_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 2,
  parameter int RX_WATERMARK = 2
) (
  input  logic                  PCLK,
  input  logic                  CLEAR_B,
  input  logic                  PSEL,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] RxData,
  input  logic                  NextWord,
  input  logic                  Flush,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  SSPRXINTR,
  output logic                  SSPRORINTR,
  output logic                  RxEmpty,
  output logic                  RxFull,
  output logic [ADDR_WIDTH:0]   RxLevel
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LVL_WM   = (ADDR_WIDTH+1)'(RX_WATERMARK);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic                  ovr_q, ovr_d;

  logic empty, full, pop, push, wr_en;

  assign empty = (level_q == '0);
  assign full  = (level_q == LVL_FULL);
  assign pop   = PSEL && !PWRITE && !empty;
  // A pop in the same edge frees the slot, so a push into a full FIFO is legal then.
  assign push  = NextWord && (!full || pop);
  assign wr_en = push && !Flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    ovr_d    = ovr_q;
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
      ovr_d    = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      if (push) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (push && !pop)      level_d = level_q + (ADDR_WIDTH+1)'(1);
      else if (pop && !push) level_d = level_q - (ADDR_WIDTH+1)'(1);
      // Pop clears the sticky flag and outranks a coincident overrun attempt.
      if (pop)                 ovr_d = 1'b0;
      else if (NextWord && full) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovr_q    <= ovr_d;
    end
  end

  // Storage is not reset; the empty gate on PRDATA hides stale contents.
  always_ff @(posedge PCLK) begin
    if (wr_en) mem_q[wr_ptr_q] <= RxData;
  end

  assign PRDATA     = empty ? '0 : mem_q[rd_ptr_q];
  assign SSPRXINTR  = (level_q >= LVL_WM);
  assign SSPRORINTR = ovr_q;
  assign RxEmpty    = empty;
  assign RxFull     = full;
  assign RxLevel    = level_q;

endmodule

// File: doc/ssp_rx_fifo_param.md
Name: ssp_rx_fifo_param

Overview:
Parametrised receive FIFO for the SSP, the successor to the fixed 8-bit receive FIFO. It buffers words strobed in from the SSP receive shifter and presents them to the APB read path. Over the fixed version it adds:
- configurable data width and depth;
- a programmable watermark interrupt;
- a sticky overrun interrupt;
- full/empty/level status;
- a synchronous flush.

Parameters:
DATA_WIDTH, 8, width of each stored word and of RxData/PRDATA.
ADDR_WIDTH, 2, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 4 entries).
RX_WATERMARK, 2, SSPRXINTR asserts when level >= this value; legal range 1..DEPTH.

Ports:
PCLK  in  1  single clock; all state changes on rising edge.
CLEAR_B  in  1  asynchronous active-low reset.
PSEL  in  1  APB select for the receive data register.
PWRITE  in  1  APB direction; 0 = read.
RxData  in  DATA_WIDTH  word from the receive shifter.
NextWord  in  1  push strobe; one word pushed per rising edge sampled high.
Flush  in  1  synchronous flush; empties the FIFO and clears overrun.
PRDATA  out  DATA_WIDTH  head-of-FIFO word (first-word fall-through).
SSPRXINTR  out  1  receive watermark interrupt.
SSPRORINTR  out  1  sticky receive-overrun interrupt.
RxEmpty  out  1  level == 0.
RxFull  out  1  level == DEPTH.
RxLevel  out  ADDR_WIDTH+1  number of stored words, 0..DEPTH.

Behaviour:
- Reset (CLEAR_B low, asynchronous):
  - read and write pointers = 0, level = 0, overrun = 0;
  - PRDATA = 0, SSPRXINTR = 0, SSPRORINTR = 0, RxEmpty = 1, RxFull = 0, RxLevel = 0;
  - storage contents need not be reset;
  - reset asserted mid-operation discards all contents immediately.
- Storage: circular buffer of DEPTH words. Read and write pointers are ADDR_WIDTH bits and wrap modulo DEPTH. The level counter is ADDR_WIDTH+1 bits.
- Pop condition: PSEL=1 and PWRITE=0 and not empty at a rising edge; the read pointer advances by 1.
  - PSEL held high for N cycles pops N words (bounded by available data).
  - Pop when empty: ignored; no pointer change, no error flag.
  - PSEL=1 with PWRITE=1 has no effect.
- Push condition: NextWord=1 at a rising edge. RxData is written at the write pointer, which then advances by 1.
- Push when full with no simultaneous pop is an overrun:
  - the word is dropped; pointers and contents are unchanged;
  - overrun is set on that edge.
- Simultaneous push and pop:
  - both take effect and the level is unchanged;
  - when full, the push is accepted (the pop frees the slot) and there is no overrun;
  - when empty, the pop is ignored and the push is accepted, so the level becomes 1.
- Level update: +1 on push only, -1 on pop only, unchanged otherwise.
- PRDATA:
  - equals mem[read pointer] when not empty, 0 when empty;
  - combinational from registered state, so the new head is valid in the cycle after the push or pop edge;
  - a word pushed into an empty FIFO appears on PRDATA one cycle after its push edge.
- Status and interrupt outputs are combinational from registered level/overrun:
  - SSPRXINTR = (level >= RX_WATERMARK);
  - SSPRORINTR = overrun;
  - RxEmpty, RxFull, RxLevel follow level directly.
- Overrun clearing: the overrun flag is sticky until a successful pop (PSEL read of a non-empty FIFO), Flush, or reset.
  - If an overrun and a pop coincide, the pop wins: the flag is cleared, the push is accepted, and there is no overrun.
- Flush=1 at a rising edge:
  - pointers = 0, level = 0, overrun = 0;
  - takes priority over any push or pop in the same cycle, which are discarded.
- No latency beyond one edge for any state change; no pipelining.

Test Plan:
- Reset then idle: hold CLEAR_B low 2 cycles, release -> RxEmpty=1, RxLevel=0, PRDATA=0, both interrupts 0; drop CLEAR_B asynchronously between edges after loading 2 words -> all outputs return to reset values before the next edge.
- Basic order: push 8'hE7, 8'h3A, 8'h29 one cycle apart -> PRDATA=E7 after the first edge; RxLevel 1,2,3; SSPRXINTR rises when RxLevel reaches 2. Then 3 single-cycle PSEL reads -> PRDATA E7, 3A, 29, then 0; RxEmpty=1; SSPRXINTR falls when RxLevel reaches 1.
- Full and overrun: push 8'h01..8'h05 consecutively -> RxFull=1 after the 4th push; 05 dropped; SSPRORINTR=1 and stays high for 10 idle cycles. One read -> PRDATA 01 consumed; SSPRORINTR=0; RxLevel=3; next head 02.
- Simultaneous push/pop at full: with FIFO full of 01..04, NextWord=1 with RxData=8'hAA and PSEL read in the same cycle -> RxLevel stays 4, SSPRORINTR stays 0; drain order 02,03,04,AA.
- Wrap-around: 10 iterations of push-then-read with values 8'h10..8'h19 -> each read returns its matching value; pointers wrap twice; RxLevel never exceeds 1.
- Flush priority: FIFO holds 3 words with overrun set; assert Flush together with NextWord and a PSEL read -> next cycle RxLevel=0, RxEmpty=1, SSPRORINTR=0, PRDATA=0. Empty read then returns nothing, with no flag and RxLevel stays 0.
